// File: rtl/mips_hazard_pkg.sv
// Shared encodings for D-stage hazard detection (Tuse/Tnew, register 0, MULT/DIV latencies).
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package mips_hazard_pkg;

    // Tuse: cycles from D until a source operand is consumed.
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles until a producer's result can be forwarded.
    localparam logic [1:0] TNEW_0 = 2'd0;
    localparam logic [1:0] TNEW_1 = 2'd1;
    localparam logic [1:0] TNEW_2 = 2'd2;

    // Default MULT/DIV occupancy after issue from E.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // $0 is hard-wired; it never carries a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // One source operand against the E and M producers.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wa,
        input logic [1:0] m_tnew
    );
        logic e_hit;
        logic m_hit;
        e_hit = (src == e_wa) && (e_tnew > tuse);
        m_hit = (src == m_wa) && (m_tnew > tuse);
        return (src != REG_ZERO) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/md_busy_ctr.sv
// MULT/DIV occupancy countdown; md_busy covers the issue cycle plus N countdown cycles.
// Latency: busy is combinational on the start pulse; countdown registered.
// Backpressure: none; a start while busy reloads the count.
module md_busy_ctr
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4          // 2**CNT_W must exceed max(MULT_CYC, DIV_CYC)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_div,
    output logic o_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYC);

    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_nz;

    assign w_cnt_nz = (r_cnt != '0);

    // Load on issue, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_div ? DIV_LOAD : MULT_LOAD;
        end else if (w_cnt_nz) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Busy is forced low during reset so a mid-window reset drops it immediately.
    always_comb begin
        o_busy = !reset && (i_start || w_cnt_nz);
    end

endmodule

// File: rtl/hazard_stall_gen.sv
// D-stage stall request: Tuse/Tnew data hazards against E/M plus HI/LO use while MULT/DIV busy.
// Latency: stall is combinational (zero cycles); optional stats counter is registered.
// Backpressure: none; the stall controller consumes stall directly. Macro: HAZARD_STALL_STATS_EN.
module hazard_stall_gen
    import mips_hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic w_hz_rs;
    logic w_hz_rt;
    logic w_md_busy;
    logic w_md_hz;
    logic w_stall;

    md_busy_ctr #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_start (E_md_start),
        .i_div   (E_md_div),
        .o_busy  (w_md_busy)
    );

    // Per-source data hazards and the combined stall, cleared during reset.
    always_comb begin
        w_hz_rs = src_hazard(D_rs, D_rs_tuse, E_wa, E_tnew, M_wa, M_tnew);
        w_hz_rt = src_hazard(D_rt, D_rt_tuse, E_wa, E_tnew, M_wa, M_tnew);
        w_md_hz = D_is_md && w_md_busy;
        w_stall = !reset && (w_hz_rs || w_hz_rt || w_md_hz);
    end

    assign stall   = w_stall;
    assign md_busy = w_md_busy;

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_gen.sv
// Self-checking bench for hazard_stall_gen: vector table for the data hazards, hand sequences for MULT/DIV windows and reset.
// Latency: checks sampled at the falling edge after inputs change just past the rising edge.
// Backpressure: n/a.
module tb_hazard_stall_gen;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        stall, md_busy;
    logic [31:0] stall_cnt;

    hazard_stall_gen dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_tuse  (D_rs_tuse),
        .D_rt_tuse  (D_rt_tuse),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .stall      (stall),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [1:0] rs_tu;
        logic [4:0] rt;
        logic [1:0] rt_tu;
        logic       is_md;
        logic [4:0] ewa;
        logic [1:0] etn;
        logic [4:0] mwa;
        logic [1:0] mtn;
        logic       exp_stall;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t   sb_q[$];
    vec_t   vecs[12];
    vec_t   idle;
    vec_t   luse;
    vec_t   mdv;
    int     n_total = 0;
    int     n_pass  = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic   prev_rst   = 1'b1;
    logic   prev_stall = 1'b0;

    function automatic vec_t mk(input logic [4:0] rs, input logic [1:0] rs_tu,
                                input logic [4:0] rt, input logic [1:0] rt_tu,
                                input logic is_md,
                                input logic [4:0] ewa, input logic [1:0] etn,
                                input logic [4:0] mwa, input logic [1:0] mtn,
                                input logic es, input logic eb);
        vec_t v;
        v.rs = rs; v.rs_tu = rs_tu; v.rt = rt; v.rt_tu = rt_tu; v.is_md = is_md;
        v.ewa = ewa; v.etn = etn; v.mwa = mwa; v.mtn = mtn;
        v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    // One cycle: drive after the rising edge, queue the expectation, compare at the falling edge.
    task automatic step(input string name, input vec_t v, input logic rst,
                        input logic start, input logic div,
                        input logic es, input logic eb);
        exp_t e;
        exp_t got;
        @(posedge clk);
`ifdef HAZARD_STALL_STATS_EN
        if (prev_rst) exp_cnt = 32'd0;
        else if (prev_stall && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
`else
        exp_cnt = 32'd0;
`endif
        #1;
        reset = rst;
        D_rs = v.rs; D_rs_tuse = v.rs_tu; D_rt = v.rt; D_rt_tuse = v.rt_tu;
        D_is_md = v.is_md; E_wa = v.ewa; E_tnew = v.etn; M_wa = v.mwa; M_tnew = v.mtn;
        E_md_start = start; E_md_div = div;
        e.stall = es; e.busy = eb; e.cnt = exp_cnt;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        check1({name, ".stall"},     {31'd0, stall},   {31'd0, got.stall});
        check1({name, ".md_busy"},   {31'd0, md_busy}, {31'd0, got.busy});
        check1({name, ".stall_cnt"}, stall_cnt,        got.cnt);
        prev_rst   = rst;
        prev_stall = es;
    endtask

    initial begin
        reset = 1'b1;
        D_rs = 5'd0; D_rt = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; D_is_md = 1'b0;
        E_wa = 5'd0; E_tnew = 2'd0; M_wa = 5'd0; M_tnew = 2'd0;
        E_md_start = 1'b0; E_md_div = 1'b0;

        //         rs   tu    rt   tu   md   ewa  etn   mwa  mtn   stall busy
        vecs[0]  = mk(5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd2, 5'd0, 2'd0, 1'b1, 1'b0);
        vecs[1]  = mk(5'd8, 2'd0, 5'd0, 2'd3, 1'b0, 5'd8, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[2]  = mk(5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[3]  = mk(5'd9, 2'd0, 5'd0, 2'd3, 1'b0, 5'd3, 2'd2, 5'd9, 2'd1, 1'b1, 1'b0);
        vecs[4]  = mk(5'd9, 2'd1, 5'd0, 2'd3, 1'b0, 5'd3, 2'd2, 5'd9, 2'd1, 1'b0, 1'b0);
        vecs[5]  = mk(5'd6, 2'd3, 5'd0, 2'd3, 1'b0, 5'd6, 2'd2, 5'd6, 2'd1, 1'b0, 1'b0);
        vecs[6]  = mk(5'd0, 2'd3, 5'd5, 2'd1, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1, 1'b0);
        vecs[7]  = mk(5'd0, 2'd3, 5'd5, 2'd2, 1'b0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[8]  = mk(5'd0, 2'd3, 5'd7, 2'd0, 1'b0, 5'd1, 2'd0, 5'd7, 2'd2, 1'b1, 1'b0);
        vecs[9]  = mk(5'd4, 2'd0, 5'd7, 2'd0, 1'b0, 5'd5, 2'd2, 5'd9, 2'd1, 1'b0, 1'b0);
        vecs[10] = mk(5'd0, 2'd3, 5'd0, 2'd3, 1'b1, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        vecs[11] = mk(5'd4, 2'd1, 5'd7, 2'd0, 1'b0, 5'd4, 2'd2, 5'd7, 2'd1, 1'b1, 1'b0);

        idle = mk(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0);
        luse = vecs[0];
        mdv  = vecs[10];

        // Reset forces outputs low even with a live hazard and a MULT start on the inputs.
        step("rst0", luse, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rst1", mdv,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // The start seen during reset must not have loaded the counter.
        step("post_rst", mdv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++)
            step($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0, 1'b0,
                 vecs[i].exp_stall, vecs[i].exp_busy);

        // DIV issued at k=0 with an md instruction held in D: busy/stall for k=0..10.
        for (int k = 0; k < 13; k++)
            step($sformatf("div_k%0d", k), mdv, 1'b0, (k == 0), 1'b1, (k <= 10), (k <= 10));

        // MULT window: busy for k=0..5; data-independent D sees busy without stalling.
        for (int k = 0; k < 8; k++)
            step($sformatf("mult_k%0d", k), (k < 3) ? idle : mdv, 1'b0, (k == 0), 1'b0,
                 (k >= 3) && (k <= 5), (k <= 5));

        // Reset two cycles into a MULT aborts the window with no residual stall.
        step("rmid_t0", mdv, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("rmid_t1", mdv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("rmid_t2", mdv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 3; k < 7; k++)
            step($sformatf("rmid_t%0d", k), mdv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Seven stall cycles, a quiet cycle to read the total, then reset clears it.
        for (int k = 0; k < 7; k++)
            step($sformatf("stat_s%0d", k), luse, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("stat_hold", idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_STALL_STATS_EN
        check1("stat_total", stall_cnt, 32'd7);
`else
        check1("stat_total", stall_cnt, 32'd0);
`endif
        step("stat_rst", luse, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("stat_clr", idle, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check1("stat_cleared", stall_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
